// File: rtl/baseline_estimator.sv
// Sequences the baseline ROM and tracks a sliding-window mean of the ADC samples.
// Each captured sample is emitted with its running baseline and baseline-subtracted value.
module baseline_estimator #(
    parameter int ADDR_W   = 9,
    parameter int DATA_W   = 14,
    parameter int LOG2_WIN = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              loop,
    output logic [ADDR_W-1:0] rdaddr,
    input  logic [DATA_W-1:0] adc_val,
    output logic [DATA_W-1:0] sample_out,
    output logic              sample_valid,
    output logic [DATA_W-1:0] baseline,
    output logic              baseline_valid,
    output logic [DATA_W:0]   corrected,
    output logic              busy,
    output logic              done
);

    localparam int WIN   = 1 << LOG2_WIN;
    localparam int ACC_W = DATA_W + LOG2_WIN;

    typedef enum logic [1:0] {IDLE, FILL, RUN, DONE} state_t;

    state_t              state_reg, state_next;
    logic [ADDR_W-1:0]   addr_reg, addr_next;
    logic [LOG2_WIN-1:0] ptr_reg, ptr_next;
    logic [ACC_W-1:0]    acc_reg, acc_next;
    logic                bval_reg, bval_next;
    logic [DATA_W-1:0]   sample_reg;
    logic                svalid_reg;
    logic [DATA_W-1:0]   base_reg, base_next;
    logic [DATA_W:0]     corr_reg, corr_next;
    logic                capture;

    logic [DATA_W-1:0]   win_mem [WIN];
    logic [DATA_W-1:0]   oldest_reg;

    always_comb begin
        state_next = state_reg;
        addr_next  = addr_reg;
        ptr_next   = ptr_reg;
        acc_next   = acc_reg;
        bval_next  = bval_reg;
        capture    = 1'b0;
        case (state_reg)
            IDLE: begin
                bval_next = 1'b0;
                if (start) begin
                    state_next = FILL;
                    addr_next  = '0;
                    ptr_next   = '0;
                    acc_next   = '0;
                end
            end
            FILL: begin
                capture   = 1'b1;
                acc_next  = acc_reg + ACC_W'(adc_val);
                ptr_next  = ptr_reg + 1'b1;
                addr_next = addr_reg + 1'b1;
                if (ptr_reg == LOG2_WIN'(WIN - 1)) begin
                    state_next = RUN;
                    bval_next  = 1'b1;
                end
            end
            RUN: begin
                capture   = 1'b1;
                // oldest_reg holds the entry about to be overwritten at ptr_reg
                acc_next  = acc_reg + ACC_W'(adc_val) - ACC_W'(oldest_reg);
                ptr_next  = ptr_reg + 1'b1;
                addr_next = addr_reg + 1'b1;
            end
            DONE: begin
                state_next = IDLE;
                bval_next  = 1'b0;
            end
            default: state_next = IDLE;
        endcase
        // Address counter wraps naturally; without loop the pass ends here.
        if (capture && (addr_reg == {ADDR_W{1'b1}}) && !loop)
            state_next = DONE;
        base_next = acc_next[ACC_W-1:LOG2_WIN];
        corr_next = {1'b0, adc_val} - {1'b0, base_next};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            addr_reg   <= '0;
            ptr_reg    <= '0;
            acc_reg    <= '0;
            bval_reg   <= 1'b0;
            sample_reg <= '0;
            svalid_reg <= 1'b0;
            base_reg   <= '0;
            corr_reg   <= '0;
        end else begin
            state_reg  <= state_next;
            addr_reg   <= addr_next;
            ptr_reg    <= ptr_next;
            acc_reg    <= acc_next;
            bval_reg   <= bval_next;
            svalid_reg <= capture;
            if (capture) begin
                sample_reg <= adc_val;
                base_reg   <= base_next;
                corr_reg   <= corr_next;
            end
        end
    end

    // Window buffer: the read is registered one cycle ahead, prefetching the
    // slot the next capture will overwrite (never the slot written this cycle).
    always_ff @(posedge clk) begin
        if (capture)
            win_mem[ptr_reg] <= adc_val;
        oldest_reg <= win_mem[ptr_next];
    end

    assign rdaddr         = addr_reg;
    assign sample_out     = sample_reg;
    assign sample_valid   = svalid_reg;
    assign baseline       = base_reg;
    assign baseline_valid = bval_reg;
    assign corrected      = corr_reg;
    assign busy           = (state_reg == FILL) || (state_reg == RUN);
    assign done           = (state_reg == DONE);

endmodule

// File: tb/tb_baseline_estimator.sv
// Directed bench for baseline_estimator: constant, ramp, looped ramp, reset,
// ignored start and extreme-value ROM models, checked per captured sample.
module tb_baseline_estimator;

    localparam int M_CONST = 0;
    localparam int M_RAMP  = 1;
    localparam int M_ALT   = 2;
    localparam int M_MAX   = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        loop = 1'b0;
    logic [8:0]  rdaddr;
    logic [13:0] adc_val;
    logic [13:0] sample_out;
    logic        sample_valid;
    logic [13:0] baseline;
    logic        baseline_valid;
    logic [14:0] corrected;
    logic        busy;
    logic        done;

    int mode = M_CONST;
    int checks = 0;
    int errors = 0;

    baseline_estimator dut (
        .clk(clk), .rst(rst), .start(start), .loop(loop), .rdaddr(rdaddr),
        .adc_val(adc_val), .sample_out(sample_out), .sample_valid(sample_valid),
        .baseline(baseline), .baseline_valid(baseline_valid), .corrected(corrected),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    function automatic int rom(input int m, input int a);
        case (m)
            M_CONST: return 4780;
            M_RAMP:  return 4096 + a;
            M_ALT:   return (a % 2 == 1) ? 16383 : 0;
            default: return 16383;
        endcase
    endfunction

    always_comb adc_val = 14'(rom(mode, int'(rdaddr)));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    function automatic logic [31:0] corr32();
        return {{17{corrected[14]}}, corrected};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_rdaddr"}, 32'(rdaddr), 0);
        chk({tag, "_sample_out"}, 32'(sample_out), 0);
        chk({tag, "_sample_valid"}, 32'(sample_valid), 0);
        chk({tag, "_baseline"}, 32'(baseline), 0);
        chk({tag, "_bvalid"}, 32'(baseline_valid), 0);
        chk({tag, "_corrected"}, 32'(corrected), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
    endtask

    // Starts a pass and checks every captured sample against a window model
    // plus hand-computed spot values. start is re-pulsed at sample pulse_at.
    task automatic run_pass(input int m, input int nsamp, input bit lp, input int pulse_at);
        int hist[$];
        int sum, a, x, eb, last;
        mode = m;
        loop = lp;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_busy", 32'(busy), 1);
        chk("start_rdaddr", 32'(rdaddr), 0);
        chk("start_svalid", 32'(sample_valid), 0);
        chk("start_bvalid", 32'(baseline_valid), 0);
        for (int k = 0; k < nsamp; k++) begin
            start = (k == pulse_at);
            tick();
            start = 1'b0;
            a = k % 512;
            x = rom(m, a);
            hist.push_back(x);
            if (hist.size() > 16) void'(hist.pop_front());
            sum = 0;
            foreach (hist[i]) sum += hist[i];
            eb = sum / 16;
            last = (a == 511 && !lp) ? 1 : 0;
            chk("svalid", 32'(sample_valid), 1);
            chk("sample_out", 32'(sample_out), x);
            chk("rdaddr", 32'(rdaddr), (a + 1) % 512);
            chk("baseline", 32'(baseline), eb);
            chk("corrected", corr32(), x - eb);
            chk("bvalid", 32'(baseline_valid), (k >= 15) ? 1 : 0);
            chk("done", 32'(done), last);
            chk("busy", 32'(busy), 1 - last);
            if (m == M_CONST && k == 0) begin
                chk("const_s0_base", 32'(baseline), 298);
                chk("const_s0_corr", corr32(), 4482);
            end
            if (m == M_CONST && k >= 15) begin
                chk("const_base", 32'(baseline), 4780);
                chk("const_corr", corr32(), 0);
            end
            if (m == M_RAMP && k == 15) begin
                chk("ramp_s15_base", 32'(baseline), 4103);
                chk("ramp_s15_corr", corr32(), 8);
            end
            if (m == M_RAMP && k >= 15 && k < 512) begin
                chk("ramp_base", 32'(baseline), 4096 + k - 8);
                chk("ramp_corr", corr32(), 8);
            end
            if (m == M_RAMP && k == 512) begin
                chk("wrap_sample", 32'(sample_out), 4096);
                chk("wrap_base", 32'(baseline), 4568);
                chk("wrap_corr", corr32(), -472);
                chk("wrap_busy", 32'(busy), 1);
                chk("wrap_done", 32'(done), 0);
            end
            if (m == M_ALT && k >= 15) begin
                chk("alt_base", 32'(baseline), 8191);
                chk("alt_corr", corr32(), (a % 2 == 1) ? 8192 : -8191);
            end
            if (m == M_MAX && k >= 15) begin
                chk("max_base", 32'(baseline), 16383);
                chk("max_corr", corr32(), 0);
            end
        end
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_zero(tag);
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        chk_zero("reset");
        rst = 1'b0;
        tick();
        chk_zero("idle");

        // Constant pass with a stray start pulse at sample 100
        run_pass(M_CONST, 512, 1'b0, 100);
        tick();
        chk("end_svalid", 32'(sample_valid), 0);
        chk("end_busy", 32'(busy), 0);
        chk("end_done", 32'(done), 0);
        chk("end_bvalid", 32'(baseline_valid), 0);
        chk("end_rdaddr", 32'(rdaddr), 0);
        tick();
        chk("idle_hold_busy", 32'(busy), 0);

        // Looped ramp through the wrap, then reset at sample 200 of lap two
        run_pass(M_RAMP, 512 + 201, 1'b1, -1);
        do_reset("midpass_rst");
        tick();
        chk_zero("post_rst_idle");

        // Re-start after reset: window must refill before baseline_valid
        run_pass(M_RAMP, 20, 1'b0, -1);
        do_reset("rst2");

        // Extremes
        run_pass(M_ALT, 40, 1'b0, -1);
        do_reset("rst3");
        run_pass(M_MAX, 40, 1'b0, -1);
        do_reset("rst4");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/baseline_estimator.md
# baseline_estimator

Sequencer and running-baseline stage directly downstream of the pseudo-ROM baseline data source. It drives the ROM read address, captures each 14-bit ADC sample and keeps a sliding-window mean over the last 2^LOG2_WIN samples. It outputs each sample with its current baseline and the baseline-subtracted value for the droop/drift correction path.

## Interface
- ADDR_W, 9, ROM address width; the block plays back 2^ADDR_W samples per pass.
- DATA_W, 14, ADC sample width (unsigned).
- LOG2_WIN, 4, log2 of the averaging window length (window WIN = 16).

- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  starts one playback pass; sampled only in IDLE.
- loop  in  1  1 = wrap address to 0 after the last entry and continue; sampled at the last address.
- rdaddr  out  ADDR_W  ROM read address (ROM read is combinational, same cycle).
- adc_val  in  DATA_W  ROM data for rdaddr.
- sample_out  out  DATA_W  registered sample.
- sample_valid  out  1  sample_out/baseline/corrected updated this cycle.
- baseline  out  DATA_W  floor(window sum / WIN).
- baseline_valid  out  1  window fully populated since start/reset.
- corrected  out  DATA_W+1  signed, sample_out − baseline.
- busy  out  1  high in FILL and RUN.
- done  out  1  one-cycle pulse in DONE.

## Operation
- States: IDLE, FILL, RUN, DONE.
- IDLE: rdaddr=0; start=1 → FILL, address counter 0, accumulator and fill counter cleared, window buffer contents don't-care.
- FILL: each cycle capture adc_val, push it into the WIN-deep circular buffer, acc += x. After WIN captures → RUN and baseline_valid=1 (held until IDLE/reset).
- RUN: acc += x − oldest (entry overwritten by x).
- Every capture cycle: address counter increments. At address 2^ADDR_W−1: loop=1 → wrap to 0 and stay in FILL/RUN with the buffer and accumulator preserved; loop=0 → DONE.
- DONE: one cycle, done=1, then IDLE.
- Arithmetic: acc width DATA_W+LOG2_WIN (18 bits, cannot overflow). baseline = acc_next >> LOG2_WIN (truncating), where acc_next includes the current sample. corrected = {0,sample} − {0,baseline}, two's complement.
- Before baseline_valid: baseline and corrected still update from the partial sum divided by WIN. Consumers must ignore them.
- start while busy/DONE: ignored. loop changes away from the last address: no effect.
- rst at any time: next cycle IDLE, all outputs 0, acc and counters cleared. An in-flight pass is abandoned with no done pulse.

## Timing
- Reset values: rdaddr=0, sample_out=0, sample_valid=0, baseline=0, baseline_valid=0, corrected=0, busy=0, done=0.
- Edge E0 samples start=1 → busy=1, rdaddr=0 in the following cycle.
- Edge Ek+1 captures the sample at address k.
  - sample_valid=1 in that cycle, with sample_out=ROM[k] and baseline/corrected including ROM[k].
  - rdaddr=k+1 in the same cycle.
- Latency is 1 cycle from rdaddr to output; throughput is 1 sample/cycle, with no gaps across a wrap.
- baseline_valid first goes high with the sample at address WIN−1 (after E16).
- Non-loop pass:
  - E512 captures address 511 and enters DONE. That cycle: sample_valid=1, done=1, busy=0.
  - E513 → IDLE with sample_valid=0. Total 513 cycles from start edge to IDLE.

## Test plan
- Constant ROM model 4780, start, loop=0:
  - sample_valid for exactly 512 consecutive cycles.
  - baseline=4780 and corrected=0 from sample 15 on; baseline_valid rises after E16.
  - done one cycle coinciding with sample 511.
- Ramp model adc_val=4096+rdaddr:
  - At sample 15: baseline=4103, corrected=+8.
  - For all k≥15: baseline=4096+k−8, corrected=+8.
- Ramp model, loop=1: the sample after 511 is address 0 with sample_out=4096, baseline=4568, corrected=−472; busy stays 1 and no done pulse.
- Reset mid-pass: assert rst at sample 200.
  - Next cycle all outputs 0, state IDLE.
  - Re-start yields sample 0 after 1 cycle, and baseline_valid rises again only after 16 samples.
- start pulsed again at sample 100 of an active pass: no effect on address sequence or outputs.
- Extremes: ROM model alternating 0/16383 gives baseline=8191 after the window fills. Corrected alternates −8191/+8192 with no wrap, and all-16383 gives corrected=0 (accumulator max 262128 fits 18 bits).
